logic_sweep_checker: RTL and testbench

- Synthesizable, self-checking stimulus sequencer for the two-operand bitwise AND/OR stage.
- Drives exhaustive x/y operand pairs into that stage and holds each pair for a programmable number of cycles.
- Samples the stage's AND/OR results on the last cycle of each vector and counts mismatches.
- Reports pass/fail on board I/O, so the sweep needs no simulator testbench.

---
 rtl/logic_sweep_checker_if.sv | 26 ++
 rtl/logic_sweep_checker.sv | 146 ++++++++++++++
 tb/tb_logic_sweep_checker.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_sweep_checker_if.sv
// Bundle between the sweep sequencer (master) and the stage/board side (slave):
// operands out, stage results back, plus start and the status/result outputs.
interface logic_sweep_checker_if #(
    parameter int WIDTH = 2
);
    logic                 start;
    logic [WIDTH-1:0]     x_out;
    logic [WIDTH-1:0]     y_out;
    logic [WIDTH-1:0]     and_in;
    logic [WIDTH-1:0]     or_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2*WIDTH:0]     err_count;
    logic [2*WIDTH-1:0]   vector_idx;

    modport master (
        input  start, and_in, or_in,
        output x_out, y_out, busy, done, pass, err_count, vector_idx
    );

    modport slave (
        output start, and_in, or_in,
        input  x_out, y_out, busy, done, pass, err_count, vector_idx
    );
endinterface

// File: rtl/logic_sweep_checker.sv
// Exhaustive x/y sweep of a bitwise AND/OR stage with mismatch counting and pass/fail.
// Optional macro SWEEP_HALT_ON_FAIL_EN stops at the first failing vector and freezes its operands.
module logic_sweep_checker #(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_sweep_checker_if.master bus
);
    localparam int IW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam logic [IW-1:0]    IDX_LAST  = {IW{1'b1}};
    localparam logic [IW-1:0]    IDX_ZERO  = {IW{1'b0}};
    localparam logic [EW-1:0]    ERR_ZERO  = {EW{1'b0}};
    localparam logic [WIDTH-1:0] OP_ZERO   = {WIDTH{1'b0}};
    localparam logic [15:0]      HOLD_LAST = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt, w_idx_inc;
    logic [15:0]      r_hold, w_hold_nxt;
    logic [EW-1:0]    r_err, w_err_nxt, w_err_sum;
    logic [WIDTH-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_pass, w_pass_nxt;
    logic             w_mismatch, w_last_hold, w_last_vec, w_halt;

    assign w_mismatch  = (bus.and_in != (r_x & r_y)) || (bus.or_in != (r_x | r_y));
    assign w_last_hold = (r_hold == HOLD_LAST);
    assign w_last_vec  = (r_idx == IDX_LAST);
    assign w_idx_inc   = r_idx + {{(IW-1){1'b0}}, 1'b1};
    assign w_err_sum   = r_err + {{(EW-1){1'b0}}, w_mismatch};

`ifdef SWEEP_HALT_ON_FAIL_EN
    assign w_halt = w_mismatch;
`else
    assign w_halt = 1'b0;
`endif

    // Next-state and next-output logic for the sweep sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_err_nxt   = r_err;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_APPLY;
                    w_idx_nxt   = IDX_ZERO;
                    w_hold_nxt  = 16'd0;
                    w_err_nxt   = ERR_ZERO;
                    w_x_nxt     = OP_ZERO;
                    w_y_nxt     = OP_ZERO;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_APPLY: begin
                if (!w_last_hold) begin
                    w_hold_nxt = r_hold + 16'd1;
                end else if (w_halt) begin
                    // Operands and index stay on the failing vector for the board display
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = w_err_sum;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b0;
                end else if (w_last_vec) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = w_err_sum;
                    w_x_nxt     = OP_ZERO;
                    w_y_nxt     = OP_ZERO;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_sum == ERR_ZERO);
                end else begin
                    w_err_nxt  = w_err_sum;
                    w_idx_nxt  = w_idx_inc;
                    w_hold_nxt = 16'd0;
                    w_x_nxt    = w_idx_inc[IW-1:WIDTH];
                    w_y_nxt    = w_idx_inc[WIDTH-1:0];
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = IDX_ZERO;
                w_hold_nxt  = 16'd0;
                w_err_nxt   = ERR_ZERO;
                w_x_nxt     = OP_ZERO;
                w_y_nxt     = OP_ZERO;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
                w_pass_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= IDX_ZERO;
            r_hold  <= 16'd0;
            r_err   <= ERR_ZERO;
            r_x     <= OP_ZERO;
            r_y     <= OP_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
            r_err   <= w_err_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    assign bus.x_out      = r_x;
    assign bus.y_out      = r_y;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.vector_idx = r_idx;
endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: table-driven fault sweeps, randomized fault maps scored by a
// vector-level model, plus reset, restart and short-hold sequences. Honors SWEEP_HALT_ON_FAIL_EN.
module tb_logic_sweep_checker;
    localparam int W  = 2;
    localparam int NV = 16;
    localparam int H  = 20;
    localparam int H2 = 2;

    typedef struct {
        string name;
        int    mode;
        int    exp_err;
        int    exp_pass;
        int    exp_lat;
        int    exp_idx;
        int    exp_x;
        int    exp_y;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests;
    int   fails;
    int   stage_mode;
    logic [1:0] and_mask [NV];
    logic [1:0] or_mask  [NV];

    always #5 clk = ~clk;

    logic_sweep_checker_if #(.WIDTH(W)) bus0 ();
    logic_sweep_checker_if #(.WIDTH(W)) bus1 ();

    logic_sweep_checker #(.WIDTH(W), .HOLD_CYCLES(H))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    logic_sweep_checker #(.WIDTH(W), .HOLD_CYCLES(H2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Stage under test: mode 1 = AND stuck 00, mode 2 = OR stuck 11, otherwise masks flip result bits
    assign bus0.and_in = (stage_mode == 1) ? 2'b00
                       : ((bus0.x_out & bus0.y_out) ^ and_mask[{bus0.x_out, bus0.y_out}]);
    assign bus0.or_in  = (stage_mode == 2) ? 2'b11
                       : ((bus0.x_out | bus0.y_out) ^ or_mask[{bus0.x_out, bus0.y_out}]);
    assign bus1.and_in = bus1.x_out & bus1.y_out;
    assign bus1.or_in  = bus1.x_out | bus1.y_out;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Count failing vectors of the whole x/y space and find the first one
    function automatic void model(input int mode, output int cnt, output int first);
        int x, y, a, o, sa, so;
        cnt   = 0;
        first = -1;
        for (int i = 0; i < NV; i++) begin
            x  = i / (1 << W);
            y  = i % (1 << W);
            a  = x & y;
            o  = x | y;
            sa = (mode == 1) ? 0 : (a ^ int'(and_mask[i]));
            so = (mode == 2) ? 3 : (o ^ int'(or_mask[i]));
            if (sa != a || so != o) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endfunction

    function automatic vec_t expect_of(input string name, input int mode);
        vec_t v;
        int   cnt, first;
        model(mode, cnt, first);
        v.name     = name;
        v.mode     = mode;
        v.exp_err  = cnt;
        v.exp_pass = (cnt == 0) ? 1 : 0;
        v.exp_lat  = NV * H;
        v.exp_idx  = NV - 1;
        v.exp_x    = 0;
        v.exp_y    = 0;
`ifdef SWEEP_HALT_ON_FAIL_EN
        if (cnt > 0) begin
            v.exp_err = 1;
            v.exp_lat = (first + 1) * H;
            v.exp_idx = first;
            v.exp_x   = first / (1 << W);
            v.exp_y   = first % (1 << W);
        end
`endif
        return v;
    endfunction

    function automatic int pack_walk(input int idx, input int x, input int y, input int busy);
        return (idx << 12) | (x << 8) | (y << 4) | busy;
    endfunction

    task automatic run_sweep(input vec_t v, input bit hold_start, input bit pulse_mid);
        int k;
        bit seen;
        int e;
        stage_mode = v.mode;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) bus0.start = 1'b0;
        check({v.name, " busy_on_start"}, int'(bus0.busy), 1);
        check({v.name, " err_cleared"}, int'(bus0.err_count), 0);
        check({v.name, " done_cleared"}, int'(bus0.done), 0);
        k    = 0;
        seen = 1'b0;
        while (k <= NV * H + 50 && !seen) begin
            if (bus0.done) begin
                seen = 1'b1;
            end else begin
                e = k / H;
                check({v.name, " walk"},
                      pack_walk(int'(bus0.vector_idx), int'(bus0.x_out), int'(bus0.y_out), int'(bus0.busy)),
                      pack_walk(e, e / (1 << W), e % (1 << W), 1));
                if (pulse_mid && k == 50) bus0.start = 1'b1;
                if (pulse_mid && k == 51 && !hold_start) bus0.start = 1'b0;
                @(posedge clk);
                #1;
                k++;
            end
        end
        if (!seen) check({v.name, " done_timeout"}, 0, 1);
        check({v.name, " latency"}, k, v.exp_lat);
        check({v.name, " err_count"}, int'(bus0.err_count), v.exp_err);
        check({v.name, " pass"}, int'(bus0.pass), v.exp_pass);
        check({v.name, " busy_done"}, int'(bus0.busy), 0);
        check({v.name, " final_idx"}, int'(bus0.vector_idx), v.exp_idx);
        check({v.name, " final_x"}, int'(bus0.x_out), v.exp_x);
        check({v.name, " final_y"}, int'(bus0.y_out), v.exp_y);
        if (!hold_start) begin
            @(posedge clk);
            #1;
            check({v.name, " done_sticky"}, int'(bus0.done), 1);
        end
    endtask

    vec_t tbl [3];
    vec_t rv;
    int   k2;

    initial begin
        tests      = 0;
        fails      = 0;
        stage_mode = 0;
        for (int i = 0; i < NV; i++) begin
            and_mask[i] = 2'b00;
            or_mask[i]  = 2'b00;
        end
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        rst_n      = 1'b0;

`ifdef SWEEP_HALT_ON_FAIL_EN
        tbl[0] = '{"correct",    0, 0, 1, NV * H, NV - 1, 0, 0};
        tbl[1] = '{"and_stuck0", 1, 1, 0, 6 * H,  5,      1, 1};
        tbl[2] = '{"or_stuck3",  2, 1, 0, 1 * H,  0,      0, 0};
`else
        tbl[0] = '{"correct",    0, 0, 1, NV * H, NV - 1, 0, 0};
        tbl[1] = '{"and_stuck0", 1, 7, 0, NV * H, NV - 1, 0, 0};
        tbl[2] = '{"or_stuck3",  2, 7, 0, NV * H, NV - 1, 0, 0};
`endif

        #1;
        check("rst busy", int'(bus0.busy), 0);
        check("rst done", int'(bus0.done), 0);
        check("rst pass", int'(bus0.pass), 0);
        check("rst err", int'(bus0.err_count), 0);
        check("rst idx", int'(bus0.vector_idx), 0);
        check("rst x", int'(bus0.x_out), 0);
        check("rst y", int'(bus0.y_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_wait busy", int'(bus0.busy), 0);
        check("idle_wait done", int'(bus0.done), 0);

        for (int i = 0; i < 3; i++) run_sweep(tbl[i], 1'b0, 1'b0);

        rv      = tbl[0];
        rv.name = "busy_pulse";
        run_sweep(rv, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NV; i++) begin
                and_mask[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                or_mask[i]  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            rv = expect_of($sformatf("rand%0d", r), 3);
            run_sweep(rv, 1'b0, 1'b0);
        end
        for (int i = 0; i < NV; i++) begin
            and_mask[i] = 2'b00;
            or_mask[i]  = 2'b00;
        end

        // Asynchronous reset in the middle of a sweep
        stage_mode = 0;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", int'(bus0.busy), 0);
        check("midrst done", int'(bus0.done), 0);
        check("midrst pass", int'(bus0.pass), 0);
        check("midrst err", int'(bus0.err_count), 0);
        check("midrst idx", int'(bus0.vector_idx), 0);
        check("midrst xy", int'({bus0.x_out, bus0.y_out}), 0);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst stays_idle", int'({bus0.busy, bus0.done}), 0);
        rv      = tbl[0];
        rv.name = "after_reset";
        run_sweep(rv, 1'b0, 1'b0);

        // start held high: sweep ignores it while busy, then restarts straight out of DONE
        rv      = tbl[1];
        rv.name = "start_held";
        run_sweep(rv, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("restart busy", int'(bus0.busy), 1);
        check("restart done", int'(bus0.done), 0);
        check("restart err", int'(bus0.err_count), 0);
        check("restart idx", int'(bus0.vector_idx), 0);
        bus0.start = 1'b0;
        k2 = 0;
        while (!bus0.done && k2 < NV * H + 20) begin
            @(posedge clk);
            #1;
            k2++;
        end
        check("restart completes", int'(bus0.done), 1);

        // Short hold: the whole sweep takes NV*2 cycles
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        k2 = 0;
        while (!bus1.done && k2 < 200) begin
            @(posedge clk);
            #1;
            k2++;
        end
        check("hold2 latency", k2, NV * H2);
        check("hold2 pass", int'(bus1.pass), 1);
        check("hold2 err", int'(bus1.err_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
